// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port, length, len data bits, then one idle-high gap bit.
// Every frame bit advances on a clk edge that has clken=1.
module serial_frame_tx #(
  parameter int unsigned PORT_W = 2,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              start,
  input  logic [PORT_W-1:0] port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              serOut,
  output logic              busy,
  output logic              DONE
);

  localparam logic [LEN_W-1:0] PORT_LAST = LEN_W'(PORT_W - 1);
  localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(LEN_W - 1);
  localparam logic [LEN_W-1:0] DATA_TOP  = LEN_W'(DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PORT,
    ST_LEN,
    ST_DATA,
    ST_GAP
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [PORT_W-1:0] port_sh;
  logic [LEN_W-1:0]  len_sh;
  logic [DATA_W-1:0] data_sh;
  logic [DATA_W-1:0] data_align_c;

  // Left-align the payload so data[len-1] sits at the MSB; unused upper bits fall off.
  assign data_align_c = data << (DATA_TOP - len);

  // Frame sequencer; each field shifts out MSB first from its own register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      port_sh <= '0;
      len_sh  <= '0;
      data_sh <= '0;
      serOut  <= 1'b1;
      busy    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (clken) begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              port_sh <= port;
              len_sh  <= len;
              len_q   <= len;
              data_sh <= data_align_c;
              cnt     <= '0;
              serOut  <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_PORT;
            end else begin
              serOut <= 1'b1;
            end
          end
          ST_PORT: begin
            serOut  <= port_sh[PORT_W-1];
            port_sh <= port_sh << 1;
            if (cnt == PORT_LAST) begin
              cnt   <= '0;
              state <= ST_LEN;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
          ST_LEN: begin
            serOut <= len_sh[LEN_W-1];
            len_sh <= len_sh << 1;
            if (cnt == LEN_LAST) begin
              cnt   <= '0;
              state <= (len_q != '0) ? ST_DATA : ST_GAP;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
          ST_DATA: begin
            serOut  <= data_sh[DATA_W-1];
            data_sh <= data_sh << 1;
            if (cnt == len_q - LEN_W'(1)) begin
              cnt   <= '0;
              state <= ST_GAP;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
          ST_GAP: begin
            // First edge drives the gap bit, second edge closes the frame.
            if (cnt == '0) begin
              serOut <= 1'b1;
              cnt    <= LEN_W'(1);
            end else begin
              cnt   <= '0;
              busy  <= 1'b0;
              DONE  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: begin
            cnt    <= '0;
            serOut <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized scoreboard bench for serial_frame_tx: the driver queues each accepted request,
// and a monitor rebuilds frames from the line and checks them against a field-level model.
module tb_serial_frame_tx;

  localparam int unsigned PORT_W = 2;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              clken;
  logic              start;
  logic [PORT_W-1:0] port;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] data;
  logic              serOut;
  logic              busy;
  logic              DONE;

  typedef struct packed {
    logic [PORT_W-1:0] p;
    logic [LEN_W-1:0]  l;
    logic [DATA_W-1:0] d;
  } req_t;

  req_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;   // 0: clken tied high, 1: one in four, 2: random gaps

  logic [PORT_W-1:0] nxt_p;
  logic [LEN_W-1:0]  nxt_l;
  logic [DATA_W-1:0] nxt_d;

  serial_frame_tx #(.PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .clken(clken), .start(start), .port(port),
    .len(len), .data(data), .serOut(serOut), .busy(busy), .DONE(DONE)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected line bits for one request, packed behind a leading 1 marker so length is visible.
  function automatic logic [63:0] model_frame(input req_t r);
    logic [63:0] v;
    v = 64'd1;
    v = {v[62:0], 1'b0};
    for (int i = PORT_W - 1; i >= 0; i--) v = {v[62:0], r.p[i]};
    for (int i = LEN_W - 1; i >= 0; i--) v = {v[62:0], r.l[i]};
    for (int i = int'(r.l) - 1; i >= 0; i--) v = {v[62:0], r.d[i]};
    v = {v[62:0], 1'b1};
    return v;
  endfunction

  task automatic step(input logic ce);
    clken = ce;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clken_edge();
    int gap;
    gap = (mode == 0) ? 0 : (mode == 1) ? 3 : int'($urandom_range(0, 3));
    repeat (gap) step(1'b0);
    step(1'b1);
  endtask

  // kind 0: inputs scrambled after accept; 1: plus random start pulses; 2: start held with next request
  task automatic run_frame(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic [DATA_W-1:0] d, input int kind);
    req_t r;
    r.p = p; r.l = l; r.d = d;
    port = p; len = l; data = d; start = 1'b1;
    exp_q.push_back(r);
    clken_edge();
    for (int e = 2; e <= 9 + int'(l); e++) begin
      if (kind == 2) begin
        start = 1'b1; port = nxt_p; len = nxt_l; data = nxt_d;
      end else begin
        start = (kind == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        port  = PORT_W'($urandom);
        len   = LEN_W'($urandom);
        data  = DATA_W'($urandom);
      end
      clken_edge();
    end
    if (kind != 2) start = 1'b0;
  endtask

  // Monitor: samples each clk edge, rebuilds frames and compares against the queue.
  initial begin
    logic        ce;
    logic        in_frame;
    logic        prev_done;
    logic        prev_ser;
    logic [63:0] got;
    int          edges;
    req_t        r;
    in_frame = 1'b0; prev_done = 1'b0; prev_ser = 1'b1; got = '0; edges = 0;
    forever begin
      @(posedge clk);
      ce = clken;
      #1;
      if (!rst) begin
        in_frame = 1'b0; prev_done = 1'b0; prev_ser = 1'b1;
      end else begin
        if (prev_done) check("done_width", 64'(DONE), 64'd0);
        if (!ce) begin
          check("bit_hold", 64'(serOut), 64'(prev_ser));
          if (!prev_done) check("done_no_clken", 64'(DONE), 64'd0);
        end else if (!in_frame) begin
          if (DONE) check("done_outside_frame", 64'(DONE), 64'd0);
          if (busy) begin
            in_frame = 1'b1; edges = 1; got = {63'd1, serOut};
          end else begin
            check("idle_line", 64'(serOut), 64'd1);
          end
        end else begin
          edges++;
          if (DONE) begin
            check("busy_after_done", 64'(busy), 64'd0);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", got, 64'd0);
            end else begin
              r = exp_q.pop_front();
              check("frame", got, model_frame(r));
            end
            in_frame = 1'b0;
          end else begin
            check("busy_in_frame", 64'(busy), 64'd1);
            got = {got[62:0], serOut};
            if (edges > 40) begin
              check("frame_timeout", 64'(edges), 64'd25);
              in_frame = 1'b0;
            end
          end
        end
        prev_done = DONE;
        prev_ser  = serOut;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PORT_W-1:0] p;
    logic [LEN_W-1:0]  l;
    logic [DATA_W-1:0] d;
    int                kind;
    req_t              r;
    rst = 1'b1; clken = 1'b0; start = 1'b0; port = '0; len = '0; data = '0;
    #3 rst = 1'b0;
    #1;
    check("reset_serOut", 64'(serOut), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_DONE", 64'(DONE), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step(1'b1);

    // Directed frames: basic, zero length, max length throttled, busy rejection, hold-through.
    mode = 0;
    run_frame(2'b10, 4'd3, 15'b101, 0);
    run_frame(2'b11, 4'd0, 15'h7FFF, 0);
    mode = 1;
    run_frame(2'b01, 4'd15, 15'h5A5A, 0);
    mode = 0;
    run_frame(2'b00, 4'd6, 15'h0B3C, 1);
    nxt_p = 2'b01; nxt_l = 4'd2; nxt_d = 15'h0002;
    run_frame(2'b11, 4'd4, 15'h000A, 2);
    run_frame(nxt_p, nxt_l, nxt_d, 0);
    repeat (2) clken_edge();

    // Reset while in the data field: line must recover at once and the frame is dropped.
    r.p = 2'b01; r.l = 4'd5; r.d = '0;
    port = r.p; len = r.l; data = r.d; start = 1'b1;
    exp_q.push_back(r);
    clken_edge();
    start = 1'b0;
    repeat (8) clken_edge();
    #2 rst = 1'b0;
    #1;
    check("midframe_reset_serOut", 64'(serOut), 64'd1);
    check("midframe_reset_busy", 64'(busy), 64'd0);
    check("midframe_reset_DONE", 64'(DONE), 64'd0);
    exp_q.delete();
    @(negedge clk);
    repeat (3) step(1'b1);
    rst = 1'b1;
    repeat (30) step(1'b1);

    for (int n = 0; n < 150; n++) begin
      mode = int'($urandom_range(0, 2));
      p = PORT_W'($urandom); l = LEN_W'($urandom); d = DATA_W'($urandom);
      kind = int'($urandom_range(0, 2));
      if (kind == 2) begin
        nxt_p = PORT_W'($urandom); nxt_l = LEN_W'($urandom); nxt_d = DATA_W'($urandom);
        run_frame(p, l, d, 2);
        run_frame(nxt_p, nxt_l, nxt_d, 0);
      end else begin
        run_frame(p, l, d, kind);
      end
      repeat ($urandom_range(0, 2)) clken_edge();
    end

    mode = 0;
    start = 1'b0;
    repeat (5) clken_edge();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
